decode_stage_p: RTL and testbench

Parametrised decode stage for the pipelined processor: decodes one instruction word per cycle into the control word, reads operands from an internal register file with write-back bypass, and drives a registered ID/EX bundle. Unlike the single-cycle decoder it replaces, it has:
- a two-word immediate state machine;
- load-use hazard detection with bubble insertion;
- a downstream stall and flush handshake.

It sits between fetch and execute.

---
 rtl/decode_pkg.sv | 81 ++++++++
 rtl/control_decoder.sv | 15 +
 rtl/decode_stage_p.sv | 166 ++++++++++++++++
 tb/tb_decode_stage_p.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage.
//   - Opcode map (OPC_W-bit opcodes) and the control word each opcode produces.
//   - Control-word bit indices.
//   - Decode FSM state type {DEC, IMM}.
// Control word class field (bits 14:13): 0 none, 1 immediate ALU, 2 memory, 3 control flow.
package decode_pkg;

   localparam int unsigned OPC_W   = 4;
   localparam int unsigned CS_BITS = 15;

   // Control-word bit positions
   localparam int unsigned CS_ALU_OP    = 0;
   localparam int unsigned CS_ALU_SRC   = 1;
   localparam int unsigned CS_REG_WRITE = 2;
   localparam int unsigned CS_MEMR      = 3;
   localparam int unsigned CS_MEMW      = 4;
   localparam int unsigned CS_MTR       = 5;
   localparam int unsigned CS_BRANCH    = 6;
   localparam int unsigned CS_OUT       = 7;
   localparam int unsigned CS_IN        = 8;
   localparam int unsigned CS_PUSHPOP   = 9;
   localparam int unsigned CS_PUSHPC    = 10;
   localparam int unsigned CS_POPPC     = 11;
   localparam int unsigned CS_SPOP      = 12;
   localparam int unsigned CS_CLASS_LO  = 13;

   // Opcodes
   localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
   localparam logic [OPC_W-1:0] OP_ADD  = 4'h1;
   localparam logic [OPC_W-1:0] OP_SUB  = 4'h2;
   localparam logic [OPC_W-1:0] OP_ADDI = 4'h3;
   localparam logic [OPC_W-1:0] OP_LD   = 4'h4;
   localparam logic [OPC_W-1:0] OP_ST   = 4'h5;
   localparam logic [OPC_W-1:0] OP_LDD  = 4'h6;
   localparam logic [OPC_W-1:0] OP_STD  = 4'h7;
   localparam logic [OPC_W-1:0] OP_JMP  = 4'h8;
   localparam logic [OPC_W-1:0] OP_OUT  = 4'h9;
   localparam logic [OPC_W-1:0] OP_IN   = 4'hA;
   localparam logic [OPC_W-1:0] OP_PUSH = 4'hB;
   localparam logic [OPC_W-1:0] OP_POP  = 4'hC;
   localparam logic [OPC_W-1:0] OP_CALL = 4'hD;
   localparam logic [OPC_W-1:0] OP_RET  = 4'hE;
   localparam logic [OPC_W-1:0] OP_SPOP = 4'hF;

   typedef enum logic {DEC, IMM} state_e;

   function automatic logic [CS_BITS-1:0] bit_m(input int unsigned idx);
      return CS_BITS'(1) << idx;
   endfunction

   function automatic logic [CS_BITS-1:0] cls_m(input logic [1:0] cls);
      return CS_BITS'(cls) << CS_CLASS_LO;
   endfunction

   function automatic logic [CS_BITS-1:0] cs_of(input logic [OPC_W-1:0] opc);
      logic [CS_BITS-1:0] cs;
      cs = '0;
      case (opc)
         OP_ADD:  cs = bit_m(CS_REG_WRITE);
         OP_SUB:  cs = bit_m(CS_REG_WRITE) | bit_m(CS_ALU_OP);
         OP_ADDI: cs = bit_m(CS_REG_WRITE) | bit_m(CS_ALU_SRC) | cls_m(2'd1);
         OP_LD:   cs = bit_m(CS_MEMR) | bit_m(CS_REG_WRITE) | bit_m(CS_MTR) | cls_m(2'd2);
         OP_ST:   cs = bit_m(CS_MEMW) | cls_m(2'd2);
         OP_LDD:  cs = bit_m(CS_MEMR) | bit_m(CS_REG_WRITE) | bit_m(CS_MTR) | bit_m(CS_ALU_SRC)
                     | cls_m(2'd2);
         OP_STD:  cs = bit_m(CS_MEMW) | bit_m(CS_ALU_SRC) | cls_m(2'd2);
         OP_JMP:  cs = bit_m(CS_BRANCH) | bit_m(CS_ALU_SRC) | cls_m(2'd3);
         OP_OUT:  cs = bit_m(CS_OUT);
         OP_IN:   cs = bit_m(CS_IN) | bit_m(CS_REG_WRITE);
         OP_PUSH: cs = bit_m(CS_PUSHPOP) | bit_m(CS_MEMW) | cls_m(2'd2);
         OP_POP:  cs = bit_m(CS_PUSHPOP) | bit_m(CS_MEMR) | bit_m(CS_REG_WRITE) | bit_m(CS_MTR)
                     | cls_m(2'd2);
         OP_CALL: cs = bit_m(CS_PUSHPC) | bit_m(CS_BRANCH) | bit_m(CS_ALU_SRC) | cls_m(2'd3);
         OP_RET:  cs = bit_m(CS_POPPC) | bit_m(CS_BRANCH) | cls_m(2'd3);
         OP_SPOP: cs = bit_m(CS_SPOP) | bit_m(CS_REG_WRITE);
         default: cs = '0;
      endcase
      return cs;
   endfunction

endpackage

// File: rtl/control_decoder.sv
// Purely combinational opcode -> control word decoder.
//   i_opc  opcode (decode_pkg::OPC_W bits)
//   o_cs   control word (CS_W bits), layout defined in decode_pkg
import decode_pkg::*;

module control_decoder #(
   parameter int unsigned CS_W = 15
) (
   input  logic [decode_pkg::OPC_W-1:0] i_opc,
   output logic [CS_W-1:0]              o_cs
);

   assign o_cs = CS_W'(cs_of(i_opc));

endmodule

// File: rtl/decode_stage_p.sv
// Pipelined decode stage: decodes one word per cycle, reads operands from an
// internal register file with write-back bypass, and drives a registered ID/EX bundle.
// Two-word immediate instructions, load-use bubbles, and stall/flush handshake.
//   clk, reset (async active-low)
//   in_valid/instr/in_ready  fetch side handshake
//   flush, ex_stall          downstream control
//   wb_en/wb_addr/wb_data    register-file write port
//   out_*                    registered ID/EX bundle; hazard is combinational
import decode_pkg::*;

module decode_stage_p #(
   parameter  int unsigned DATA_W  = 16,
   parameter  int unsigned REG_CNT = 8,
   parameter  int unsigned CS_W    = 15,
   parameter  int unsigned OPC_W   = 4,
   localparam int unsigned AW      = $clog2(REG_CNT)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] instr,
   output logic              in_ready,
   input  logic              flush,
   input  logic              ex_stall,
   input  logic              wb_en,
   input  logic [AW-1:0]     wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              out_valid,
   output logic [CS_W-1:0]   out_cs,
   output logic [AW-1:0]     out_rd,
   output logic [AW-1:0]     out_rs1,
   output logic [AW-1:0]     out_rs2,
   output logic [DATA_W-1:0] out_rd1,
   output logic [DATA_W-1:0] out_rd2,
   output logic [DATA_W-1:0] out_imm,
   output logic              hazard
);

   localparam int unsigned PKG_OPC_W = decode_pkg::OPC_W;

   logic [DATA_W-1:0] r_rf [REG_CNT];
   state_e            r_state;
   logic [CS_W-1:0]   r_h_cs;
   logic [AW-1:0]     r_h_rs1, r_h_rs2;
   logic              r_valid;
   logic [CS_W-1:0]   r_cs;
   logic [AW-1:0]     r_rd, r_rs2;
   logic [DATA_W-1:0] r_rd1, r_rd2, r_imm;

   logic [OPC_W-1:0]     w_opc;
   logic [PKG_OPC_W-1:0] w_dec_opc;
   logic [AW-1:0]        w_rs1, w_rs2, w_ra1, w_ra2;
   logic [CS_W-1:0]      w_cs, w_ld_cs;
   logic [DATA_W-1:0]    w_rd1, w_rd2, w_ld_imm;
   logic                 w_hazard, w_ready, w_accept, w_load, w_first;

   assign w_opc     = instr[DATA_W-1 -: OPC_W];
   assign w_rs1     = instr[DATA_W-OPC_W-1 -: AW];
   assign w_rs2     = instr[DATA_W-OPC_W-AW-1 -: AW];
   assign w_dec_opc = PKG_OPC_W'(w_opc);

   control_decoder #(.CS_W(CS_W)) u_ctrl_dec (
      .i_opc (w_dec_opc),
      .o_cs  (w_cs)
   );

   // Load-use: the bundle holds a load whose destination the incoming word reads.
   assign w_hazard = (r_state == DEC) && in_valid && r_valid && r_cs[CS_MEMR]
                     && r_cs[CS_REG_WRITE] && ((r_rd == w_rs1) || (r_rd == w_rs2));

   assign w_ready  = reset && !ex_stall && !w_hazard && !flush;
   assign w_accept = in_valid && w_ready;
   // First word of an immediate instruction is parked, not loaded.
   assign w_first  = (r_state == DEC) && w_cs[CS_ALU_SRC];
   assign w_load   = w_accept && !w_first;

   // Operand addresses and bundle sources: live fields in DEC, held fields in IMM.
   assign w_ra1    = (r_state == IMM) ? r_h_rs1 : w_rs1;
   assign w_ra2    = (r_state == IMM) ? r_h_rs2 : w_rs2;
   assign w_ld_cs  = (r_state == IMM) ? r_h_cs  : w_cs;
   assign w_ld_imm = (r_state == IMM) ? instr   : '0;

   // Write-back bypass so a same-cycle write is visible to the read.
   assign w_rd1 = (wb_en && (wb_addr == w_ra1)) ? wb_data : r_rf[w_ra1];
   assign w_rd2 = (wb_en && (wb_addr == w_ra2)) ? wb_data : r_rf[w_ra2];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(REG_CNT); i++) r_rf[i] <= '0;
      end else if (wb_en) begin
         r_rf[wb_addr] <= wb_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= DEC;
         r_h_cs  <= '0;
         r_h_rs1 <= '0;
         r_h_rs2 <= '0;
         r_valid <= 1'b0;
         r_cs    <= '0;
         r_rd    <= '0;
         r_rs2   <= '0;
         r_rd1   <= '0;
         r_rd2   <= '0;
         r_imm   <= '0;
      end else if (flush) begin
         r_state <= DEC;
         r_h_cs  <= '0;
         r_h_rs1 <= '0;
         r_h_rs2 <= '0;
         r_valid <= 1'b0;
         r_cs    <= '0;
         r_rd    <= '0;
         r_rs2   <= '0;
         r_rd1   <= '0;
         r_rd2   <= '0;
         r_imm   <= '0;
      end else if (!ex_stall) begin
         case (r_state)
            DEC: begin
               if (w_accept && w_first) begin
                  r_h_cs  <= w_cs;
                  r_h_rs1 <= w_rs1;
                  r_h_rs2 <= w_rs2;
                  r_state <= IMM;
               end
            end
            IMM: begin
               if (w_accept) r_state <= DEC;
            end
            default: r_state <= DEC;
         endcase
         if (w_load) begin
            r_valid <= 1'b1;
            r_cs    <= w_ld_cs;
            r_rd    <= w_ra1;
            r_rs2   <= w_ra2;
            r_rd1   <= w_rd1;
            r_rd2   <= w_rd2;
            r_imm   <= w_ld_imm;
         end else begin
            r_valid <= 1'b0;
            r_cs    <= '0;
            r_rd    <= '0;
            r_rs2   <= '0;
            r_rd1   <= '0;
            r_rd2   <= '0;
            r_imm   <= '0;
         end
      end
   end

   assign in_ready  = w_ready;
   assign hazard    = w_hazard;
   assign out_valid = r_valid;
   assign out_cs    = r_cs;
   assign out_rd    = r_rd;
   assign out_rs1   = r_rd;
   assign out_rs2   = r_rs2;
   assign out_rd1   = r_rd1;
   assign out_rd2   = r_rd2;
   assign out_imm   = r_imm;

endmodule

// File: tb/tb_decode_stage_p.sv
// Self-checking bench for decode_stage_p: directed scenarios followed by random
// stimulus, all compared against a behavioural model of the decode stage.
module tb_decode_stage_p;

   logic        clk = 1'b0;
   logic        reset, in_valid, flush, ex_stall, wb_en;
   logic [15:0] instr, wb_data;
   logic [2:0]  wb_addr;
   logic        in_ready, out_valid, hazard;
   logic [14:0] out_cs;
   logic [2:0]  out_rd, out_rs1, out_rs2;
   logic [15:0] out_rd1, out_rd2, out_imm;

   always #5 clk = ~clk;

   decode_stage_p dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .instr    (instr),
      .in_ready (in_ready),
      .flush    (flush),
      .ex_stall (ex_stall),
      .wb_en    (wb_en),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data),
      .out_valid(out_valid),
      .out_cs   (out_cs),
      .out_rd   (out_rd),
      .out_rs1  (out_rs1),
      .out_rs2  (out_rs2),
      .out_rd1  (out_rd1),
      .out_rd2  (out_rd2),
      .out_imm  (out_imm),
      .hazard   (hazard)
   );

   typedef struct packed {
      bit        valid;
      bit [14:0] cs;
      bit [2:0]  rd;
      bit [2:0]  rs2;
      bit [15:0] rd1;
      bit [15:0] rd2;
      bit [15:0] imm;
   } bundle_t;

   // Expected control word per opcode 0..15.
   bit [14:0] cs_tab [16] = '{15'h0000, 15'h0004, 15'h0005, 15'h2006,
                              15'h402C, 15'h4010, 15'h402E, 15'h4012,
                              15'h6042, 15'h0080, 15'h0104, 15'h4210,
                              15'h422C, 15'h6442, 15'h6840, 15'h1004};

   bundle_t   m_b;
   bit [15:0] m_rf [8];
   bit [15:0] m_pend [$];   // first word of an immediate instruction awaiting its immediate
   int        n_pass = 0;
   int        n_total = 0;
   logic      s_rdy, s_hz;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic bit [3:0] f_opc(input bit [15:0] w); return 4'(w >> 12); endfunction
   function automatic bit [2:0] f_rs1(input bit [15:0] w); return 3'((w >> 9) & 7); endfunction
   function automatic bit [2:0] f_rs2(input bit [15:0] w); return 3'((w >> 6) & 7); endfunction

   function automatic bit [15:0] rf_read(input bit [2:0] a, input bit we, input bit [2:0] wa,
                                         input bit [15:0] wd);
      return (we && wa == a) ? wd : m_rf[a];
   endfunction

   function automatic bundle_t emit(input bit [15:0] w, input bit [15:0] imm, input bit we,
                                    input bit [2:0] wa, input bit [15:0] wd);
      bundle_t b;
      b.valid = 1'b1;
      b.cs    = cs_tab[f_opc(w)];
      b.rd    = f_rs1(w);
      b.rs2   = f_rs2(w);
      b.rd1   = rf_read(f_rs1(w), we, wa, wd);
      b.rd2   = rf_read(f_rs2(w), we, wa, wd);
      b.imm   = imm;
      return b;
   endfunction

   task automatic check_bundle();
      check("out_valid", 32'(out_valid), 32'(m_b.valid));
      check("out_cs",    32'(out_cs),    32'(m_b.cs));
      check("out_rd",    32'(out_rd),    32'(m_b.rd));
      check("out_rs1",   32'(out_rs1),   32'(m_b.rd));
      check("out_rs2",   32'(out_rs2),   32'(m_b.rs2));
      check("out_rd1",   32'(out_rd1),   32'(m_b.rd1));
      check("out_rd2",   32'(out_rd2),   32'(m_b.rd2));
      check("out_imm",   32'(out_imm),   32'(m_b.imm));
   endtask

   // One clock cycle: drive after negedge, check handshake, then the bundle after posedge.
   task automatic step(input bit v, input bit [15:0] ins, input bit fl, input bit st,
                       input bit we, input bit [2:0] wa, input bit [15:0] wd);
      bit      e_hz, e_rdy, acc;
      bundle_t nb;
      @(negedge clk);
      in_valid = v; instr = ins; flush = fl; ex_stall = st;
      wb_en = we; wb_addr = wa; wb_data = wd;
      #1;
      e_hz  = (m_pend.size() == 0) && v && m_b.valid && m_b.cs[3] && m_b.cs[2]
              && (m_b.rd == f_rs1(ins) || m_b.rd == f_rs2(ins));
      e_rdy = !st && !e_hz && !fl;
      s_hz  = hazard;
      s_rdy = in_ready;
      check("hazard", 32'(hazard), 32'(e_hz));
      check("in_ready", 32'(in_ready), 32'(e_rdy));
      acc = v && e_rdy;
      nb  = m_b;
      if (fl) begin
         nb = '0;
         m_pend.delete();
      end else if (!st) begin
         nb = '0;
         if (m_pend.size() == 0) begin
            if (acc && cs_tab[f_opc(ins)][1]) m_pend.push_back(ins);
            else if (acc) nb = emit(ins, 16'h0, we, wa, wd);
         end else if (acc) begin
            nb = emit(m_pend.pop_front(), ins, we, wa, wd);
         end
      end
      @(posedge clk);
      m_b = nb;
      if (we) m_rf[wa] = wd;
      #1;
      check_bundle();
   endtask

   task automatic idle_inputs();
      in_valid = 0; instr = 0; flush = 0; ex_stall = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
   endtask

   task automatic model_reset();
      m_b = '0;
      m_pend.delete();
      for (int i = 0; i < 8; i++) m_rf[i] = '0;
   endtask

   task automatic check_reset_outputs();
      check("rst_in_ready", 32'(in_ready), 32'(0));
      check("rst_hazard",   32'(hazard),   32'(0));
      check_bundle();
   endtask

   initial begin
      bit [15:0] w;
      reset = 1'b0;
      in_valid = 1; instr = 16'h4800; flush = 0; ex_stall = 0;
      wb_en = 1; wb_addr = 3; wb_data = 16'hAAAA;
      model_reset();
      #2;
      check_reset_outputs();
      @(negedge clk);
      idle_inputs();
      reset = 1'b1;
      #1;
      check("release_ready", 32'(in_ready), 32'(1));

      // Register-register op with operands written first.
      step(0, 16'h0000, 0, 0, 1, 3, 16'h1234);
      step(0, 16'h0000, 0, 0, 1, 5, 16'h00FF);
      step(1, 16'h1740, 0, 0, 0, 0, 16'h0);
      check("rr_valid", 32'(out_valid), 32'(1));
      check("rr_rd1", 32'(out_rd1), 32'h1234);
      check("rr_rd2", 32'(out_rd2), 32'h00FF);
      check("rr_imm", 32'(out_imm), 32'h0);

      // Two-word immediate instruction.
      step(1, 16'h3400, 0, 0, 0, 0, 16'h0);
      check("imm_bubble", 32'(out_valid), 32'(0));
      step(1, 16'hBEEF, 0, 0, 0, 0, 16'h0);
      check("imm_valid", 32'(out_valid), 32'(1));
      check("imm_value", 32'(out_imm), 32'hBEEF);
      check("imm_rd", 32'(out_rd), 32'(2));
      check("imm_cs", 32'(out_cs), 32'h2006);

      // Load-use hazard.
      step(1, 16'h4800, 0, 0, 0, 0, 16'h0);
      step(1, 16'h1800, 0, 0, 0, 0, 16'h0);
      check("lu_hazard", 32'(s_hz), 32'(1));
      check("lu_ready", 32'(s_rdy), 32'(0));
      check("lu_bubble", 32'(out_valid), 32'(0));
      step(1, 16'h1800, 0, 0, 0, 0, 16'h0);
      check("lu_accept", 32'(s_rdy), 32'(1));
      check("lu_rs1", 32'(out_rs1), 32'(4));

      // Flush while waiting for an immediate, then bypassed read.
      step(1, 16'h3400, 0, 0, 0, 0, 16'h0);
      step(1, 16'hBEEF, 1, 0, 0, 0, 16'h0);
      check("fl_valid", 32'(out_valid), 32'(0));
      step(1, 16'h1200, 0, 0, 1, 1, 16'h0042);
      check("fl_opcode", 32'(out_cs), 32'h0004);
      check("bypass_rd1", 32'(out_rd1), 32'h0042);

      // ex_stall holds the bundle for three cycles.
      step(1, 16'h1740, 0, 0, 0, 0, 16'h0);
      for (int i = 0; i < 3; i++) begin
         step(1, 16'h2A40, 0, 1, 0, 0, 16'h0);
         check("stall_ready", 32'(s_rdy), 32'(0));
         check("stall_cs", 32'(out_cs), 32'h0004);
      end
      step(1, 16'h2A40, 0, 0, 0, 0, 16'h0);
      check("stall_release", 32'(out_cs), 32'h0005);

      // Reset asserted while in IMM: no stale immediate afterwards.
      step(1, 16'h3400, 0, 0, 0, 0, 16'h0);
      @(negedge clk);
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      check_reset_outputs();
      @(negedge clk);
      idle_inputs();
      reset = 1'b1;
      step(1, 16'hBEEF, 0, 0, 0, 0, 16'h0);
      check("rst_imm_cs", 32'(out_cs), 32'h4210);
      check("rst_imm_imm", 32'(out_imm), 32'h0);

      // Random traffic.
      for (int n = 0; n < 600; n++) begin
         w = 16'($urandom);
         step(($urandom_range(0, 3) != 0), w, ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 4) == 0), 1'($urandom), 3'($urandom), 16'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
